frame_painter: RTL and testbench
================================

// Module: frame_painter
// PURPOSE
//  Pixel-sweep engine downstream of the splash/game-over sequencer. While wren is high it walks every
//  pixel of the WIDTH x HEIGHT frame, fetches colour from the title or game-over ROM (or a constant
//  colour) and drives x/y/colour/plot to the VGA adapter, aligned to ROM read latency.
// PARAMETERS
//  WIDTH         160     frame width in pixels
//  HEIGHT        120     frame height in pixels
//  ROM_LAT       1       ROM read latency in cycles (1..3)
//  FLASH_COLOUR  3'b100  colour that replaces black game-over pixels in flash mode
//  BORDER_COLOUR 3'b111  border colour, used only with FRAME_BORDER_EN
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-high reset
//  wren          in   1   sweep enable from the sequencer
//  showTitle     in   1   mode select: title ROM image
//  drawBlack     in   1   mode select: constant black
//  showGameOver  in   1   mode select: game-over ROM image
//  flash         in   1   mode select: game-over ROM image with black pixels tinted FLASH_COLOUR
//  rom_addr      out  15  shared ROM address = y*WIDTH + x
//  title_q       in   3   title ROM data, valid ROM_LAT cycles after rom_addr
//  gameover_q    in   3   game-over ROM data, valid ROM_LAT cycles after rom_addr
//  x             out  8   pixel column to VGA adapter
//  y             out  7   pixel row to VGA adapter
//  colour        out  3   pixel colour
//  plot          out  1   write strobe to VGA adapter
//  done          out  1   one-cycle pulse after the last pixel of a complete frame is plotted
// BEHAVIOUR
//  - Reset: state IDLE; rom_addr, x, y, colour = 0; plot = 0; done = 0; armed = 1; pipeline valid bits cleared.
//  - Mode latched when a sweep starts. Priority when several selects are high:
//    showTitle > drawBlack > showGameOver > flash.
//    wren high with no select high: no sweep starts; stays IDLE.
//  - FSM:
//    IDLE  -> SWEEP  when wren & armed & a select is high; issue address 0 that cycle.
//    SWEEP -> DRAIN  when the address WIDTH*HEIGHT-1 is issued (frame complete),
//                    or when wren drops (abort).
//    DRAIN -> IDLE   after ROM_LAT cycles, once the pipeline is empty; done pulses on the exit
//                    cycle for a complete frame only, never after an abort.
//  - Address generation is incremental: column counter cx and row counter cy, plus a linear address
//    counter. cx wraps from WIDTH-1 to 0 and increments cy. No multiplier.
//  - Pipeline: cx, cy, valid and mode are delayed ROM_LAT stages. plot = delayed valid. x, y, colour
//    are registered together with plot.
//    Latency from address issue to plot = ROM_LAT+1 cycles.
//  - Colour by mode:
//    title -> title_q
//    black -> 3'b000
//    game-over -> gameover_q
//    flash -> gameover_q==0 ? FLASH_COLOUR : gameover_q
//  - Re-arm: armed clears on entering SWEEP and sets in any cycle where wren is low. A frame is never
//    redrawn while wren stays high past completion.
//  - Abort: wren low mid-SWEEP stops address issue that cycle. Pixels already in flight are still
//    plotted. Counters return to 0 in IDLE.
//  - Select changes mid-sweep are ignored; the latched mode holds until IDLE.
//  - Reset mid-sweep: immediate return to the reset values; plot drops in the same cycle
//    (asynchronous reset).
// CONFIGURATION
//  FRAME_BORDER_EN defined: in black mode, pixels with x==0, x==WIDTH-1, y==0 or y==HEIGHT-1 get
//    BORDER_COLOUR; all other pixels stay black.
//  FRAME_BORDER_EN undefined: black mode paints every pixel 3'b000; BORDER_COLOUR is unused.
// TESTING
//  1. rst=1, then 0; wren=1, showTitle=1; title ROM model returns addr[2:0]
//     -> exactly 19200 plots; first plot (0,0) colour 0 at cycle ROM_LAT+1;
//        last plot (159,119) colour 3'b111; done pulses once.
//  2. Black frame with wren held high after done for 50 cycles -> no second sweep.
//     Drop wren 1 cycle, then raise it -> new sweep starts at address 0.
//  3. Flash mode; ROM returns 0 at even addresses and 3'b010 at odd addresses
//     -> plotted colours alternate 3'b100 / 3'b010.
//  4. wren dropped after address 500 is issued -> plots for addresses 0..500 only; no done;
//     returns to IDLE after ROM_LAT+1 cycles.
//  5. showTitle and drawBlack both high at start -> title mode.
//     Toggle to showGameOver mid-sweep -> all pixels still use title_q.
//  6. FRAME_BORDER_EN defined, black mode -> (0,5), (159,5), (7,0), (7,119) plot 3'b111;
//     (1,1) plots 3'b000. Repeat with ROM_LAT=2: plot-to-address alignment holds.

Source files
------------

// File: rtl/frame_painter_if.sv
// Sequencer/ROM/VGA-side signal bundle for frame_painter. The painter uses the slave view and its
// driver uses the master view.
interface frame_painter_if;
  logic        wren;
  logic        show_title;
  logic        draw_black;
  logic        show_game_over;
  logic        flash;
  logic [14:0] rom_addr;
  logic [2:0]  title_q;
  logic [2:0]  gameover_q;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        done;

  modport master (
    output wren, show_title, draw_black, show_game_over, flash, title_q, gameover_q,
    input  rom_addr, x, y, colour, plot, done
  );

  modport slave (
    input  wren, show_title, draw_black, show_game_over, flash, title_q, gameover_q,
    output rom_addr, x, y, colour, plot, done
  );
endinterface

// File: rtl/frame_painter.sv
// Pixel-sweep engine: walks a WIDTH x HEIGHT frame, reads colour from the title/game-over ROM and
// plots it aligned to ROM_LAT. Define FRAME_BORDER_EN to paint a border in black mode.
module frame_painter #(
  parameter int unsigned ROM_LAT      = 1,
  parameter int unsigned WIDTH        = 160,
  parameter int unsigned HEIGHT       = 120,
  parameter logic [2:0]  FLASH_COLOUR = 3'b100
`ifdef FRAME_BORDER_EN
  ,
  parameter logic [2:0]  BORDER_COLOUR = 3'b111
`endif
) (
  input logic            clk,
  input logic            rst,
  frame_painter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;
  typedef enum logic [1:0] {ModeTitle, ModeBlack, ModeGameOver, ModeFlash} mode_e;

  localparam logic [14:0] LastAddr = 15'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]  XMax     = 8'(WIDTH - 1);
`ifdef FRAME_BORDER_EN
  localparam logic [6:0]  YMax     = 7'(HEIGHT - 1);
`endif

  state_e      r_state, w_state_d;
  mode_e       r_mode, w_mode_d, w_sel_mode;
  logic        w_sel_any, w_start, w_issue, w_last, w_empty;
  logic        r_armed, r_complete, w_complete_d, r_done, w_done_d;
  logic [7:0]  r_cx, w_cx_d;
  logic [6:0]  r_cy, w_cy_d;
  logic [14:0] r_addr, w_addr_d;

  // Delay line matching ROM read latency; index ROM_LAT-1 lines up with title_q/gameover_q.
  logic [ROM_LAT-1:0] r_pv;
  logic [7:0]         r_pcx   [ROM_LAT];
  logic [6:0]         r_pcy   [ROM_LAT];
  mode_e              r_pmode [ROM_LAT];

  logic [7:0] r_x, w_px;
  logic [6:0] r_y, w_py;
  logic [2:0] r_colour, w_colour;
  logic       r_plot;

  always_comb begin
    w_sel_any  = 1'b1;
    w_sel_mode = ModeTitle;
    if (bus.show_title)          w_sel_mode = ModeTitle;
    else if (bus.draw_black)     w_sel_mode = ModeBlack;
    else if (bus.show_game_over) w_sel_mode = ModeGameOver;
    else if (bus.flash)          w_sel_mode = ModeFlash;
    else                         w_sel_any  = 1'b0;
  end

  assign w_start = (r_state == StIdle) && bus.wren && r_armed && w_sel_any;
  assign w_last  = (r_addr == LastAddr);
  assign w_empty = ~|r_pv;

  always_comb begin
    w_state_d    = r_state;
    w_mode_d     = r_mode;
    w_issue      = 1'b0;
    w_complete_d = r_complete;
    w_done_d     = 1'b0;
    w_cx_d       = r_cx;
    w_cy_d       = r_cy;
    w_addr_d     = r_addr;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_issue      = 1'b1;
          w_mode_d     = w_sel_mode;
          w_complete_d = w_last;
          w_state_d    = w_last ? StDrain : StSweep;
        end
      end
      StSweep: begin
        if (!bus.wren) begin
          w_state_d = StDrain;
        end else begin
          w_issue = 1'b1;
          if (w_last) begin
            w_state_d    = StDrain;
            w_complete_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (w_empty) begin
          w_state_d = StIdle;
          w_done_d  = r_complete;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_issue && !w_last) begin
      w_addr_d = r_addr + 15'd1;
      if (r_cx == XMax) begin
        w_cx_d = 8'd0;
        w_cy_d = r_cy + 7'd1;
      end else begin
        w_cx_d = r_cx + 8'd1;
      end
    end
    if (w_state_d != StSweep) begin
      w_cx_d   = 8'd0;
      w_cy_d   = 7'd0;
      w_addr_d = 15'd0;
    end
  end

  assign w_px = r_pcx[ROM_LAT-1];
  assign w_py = r_pcy[ROM_LAT-1];

  always_comb begin
    w_colour = 3'b000;
    case (r_pmode[ROM_LAT-1])
      ModeTitle: w_colour = bus.title_q;
      ModeBlack: begin
`ifdef FRAME_BORDER_EN
        if (w_px == 8'd0 || w_px == XMax || w_py == 7'd0 || w_py == YMax) begin
          w_colour = BORDER_COLOUR;
        end
`endif
      end
      ModeGameOver: w_colour = bus.gameover_q;
      ModeFlash:    w_colour = (bus.gameover_q == 3'b000) ? FLASH_COLOUR : bus.gameover_q;
      default:      w_colour = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_mode     <= ModeTitle;
      r_armed    <= 1'b1;
      r_complete <= 1'b0;
      r_done     <= 1'b0;
      r_cx       <= 8'd0;
      r_cy       <= 7'd0;
      r_addr     <= 15'd0;
      r_pv       <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pcx[i]   <= 8'd0;
        r_pcy[i]   <= 7'd0;
        r_pmode[i] <= ModeTitle;
      end
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'b000;
      r_plot   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_mode     <= w_mode_d;
      r_armed    <= !bus.wren ? 1'b1 : (w_start ? 1'b0 : r_armed);
      r_complete <= w_complete_d;
      r_done     <= w_done_d;
      r_cx       <= w_cx_d;
      r_cy       <= w_cy_d;
      r_addr     <= w_addr_d;
      r_pv[0]    <= w_issue;
      r_pcx[0]   <= r_cx;
      r_pcy[0]   <= r_cy;
      r_pmode[0] <= w_mode_d;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pcx[i]   <= r_pcx[i-1];
        r_pcy[i]   <= r_pcy[i-1];
        r_pmode[i] <= r_pmode[i-1];
      end
      r_plot <= r_pv[ROM_LAT-1];
      if (r_pv[ROM_LAT-1]) begin
        r_x      <= w_px;
        r_y      <= w_py;
        r_colour <= w_colour;
      end
    end
  end

  assign bus.rom_addr = r_addr;
  assign bus.x        = r_x;
  assign bus.y        = r_y;
  assign bus.colour   = r_colour;
  assign bus.plot     = r_plot;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: a ROM_LAT=1 and a ROM_LAT=2 instance share identical stimulus,
// each with its own ROM model and plot monitor.
`timescale 1ns/1ps
module tb_frame_painter;
  localparam int NPix = 19200;
`ifdef FRAME_BORDER_EN
  localparam int BorderExp = 7;
`else
  localparam int BorderExp = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic wren, show_title, draw_black, show_game_over, flash;
  int   exp_mode = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   s;

  int n_plots [2];
  int n_bad [2];
  int n_done [2];
  int prev_a [2];
  int first_cyc [2];
  int last_cyc [2];
  int done_cyc [2];
  int last_x [2];
  int last_y [2];
  int last_col [2];
  int p0 [2];
  int b0 [2];
  int d0 [2];
  logic [2:0] fb [2][NPix];

  logic [14:0] o_addr [2];
  logic [7:0]  o_x [2];
  logic [6:0]  o_y [2];
  logic [2:0]  o_col [2];
  logic        o_plot [2];
  logic        o_done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] exp_col(input int mode, input int a, input int x, input int y);
    logic [31:0] av;
    av = a;
    case (mode)
      0: return av[2:0];
      1: begin
        if (x == 0 || x == 159 || y == 0 || y == 119) return 3'(BorderExp);
        return 3'b000;
      end
      2: return av[0] ? 3'b010 : 3'b000;
      default: return av[0] ? 3'b010 : 3'b100;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    frame_painter_if bus ();
    logic [14:0] ad [3];
    int          w_a;
    logic [2:0]  w_exp;

    assign bus.wren           = wren;
    assign bus.show_title     = show_title;
    assign bus.draw_black     = draw_black;
    assign bus.show_game_over = show_game_over;
    assign bus.flash          = flash;
    assign bus.title_q        = ad[g][2:0];
    assign bus.gameover_q     = ad[g][0] ? 3'b010 : 3'b000;

    assign o_addr[g] = bus.rom_addr;
    assign o_x[g]    = bus.x;
    assign o_y[g]    = bus.y;
    assign o_col[g]  = bus.colour;
    assign o_plot[g] = bus.plot;
    assign o_done[g] = bus.done;

    assign w_a   = int'(bus.y) * 160 + int'(bus.x);
    assign w_exp = exp_col(exp_mode, w_a, int'(bus.x), int'(bus.y));

    frame_painter #(.ROM_LAT(g + 1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    always @(posedge clk) begin
      ad[0] <= bus.rom_addr;
      ad[1] <= ad[0];
      ad[2] <= ad[1];
    end

    always @(negedge clk) begin
      if (bus.plot) begin
        n_plots[g] <= n_plots[g] + 1;
        n_bad[g]   <= n_bad[g] + ((w_a != 0 && w_a != prev_a[g] + 1) ? 1 : 0)
                      + ((bus.colour != w_exp) ? 1 : 0);
        if (w_a == 0) first_cyc[g] <= cyc;
        if (w_a < NPix) fb[g][w_a] <= bus.colour;
        prev_a[g]   <= w_a;
        last_cyc[g] <= cyc;
        last_x[g]   <= int'(bus.x);
        last_y[g]   <= int'(bus.y);
        last_col[g] <= int'(bus.colour);
      end
      if (bus.done) begin
        n_done[g]   <= n_done[g] + 1;
        done_cyc[g] <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 25000 && n_done[1] <= base; i++) step(1);
    step(5);
  endtask

  task automatic snap();
    for (int g = 0; g < 2; g++) begin
      p0[g] = n_plots[g];
      b0[g] = n_bad[g];
      d0[g] = n_done[g];
    end
  endtask

  initial begin
    rst = 1'b1;
    wren = 1'b0;
    show_title = 1'b0;
    draw_black = 1'b0;
    show_game_over = 1'b0;
    flash = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("reset plot L%0d", g + 1), int'(o_plot[g]), 0);
      check_eq($sformatf("reset done L%0d", g + 1), int'(o_done[g]), 0);
      check_eq($sformatf("reset addr L%0d", g + 1), int'(o_addr[g]), 0);
      check_eq($sformatf("reset x L%0d", g + 1), int'(o_x[g]), 0);
      check_eq($sformatf("reset y L%0d", g + 1), int'(o_y[g]), 0);
      check_eq($sformatf("reset colour L%0d", g + 1), int'(o_col[g]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);

    // Full title frame
    snap();
    show_title = 1'b1;
    wren = 1'b1;
    s = cyc;
    wait_done(d0[1]);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("title plots L%0d", g + 1), n_plots[g] - p0[g], NPix);
      check_eq($sformatf("title bad pixels L%0d", g + 1), n_bad[g] - b0[g], 0);
      check_eq($sformatf("title first latency L%0d", g + 1), first_cyc[g] - s, g + 2);
      check_eq($sformatf("title last x L%0d", g + 1), last_x[g], 159);
      check_eq($sformatf("title last y L%0d", g + 1), last_y[g], 119);
      check_eq($sformatf("title last colour L%0d", g + 1), last_col[g], 7);
      check_eq($sformatf("title done count L%0d", g + 1), n_done[g] - d0[g], 1);
      check_eq($sformatf("title done after last L%0d", g + 1), done_cyc[g] - last_cyc[g], 1);
    end
    snap();
    step(50);
    for (int g = 0; g < 2; g++)
      check_eq($sformatf("title no resweep L%0d", g + 1), n_plots[g] - p0[g], 0);

    // Full black frame, then re-arm
    wren = 1'b0;
    show_title = 1'b0;
    draw_black = 1'b1;
    exp_mode = 1;
    step(1);
    snap();
    wren = 1'b1;
    wait_done(d0[1]);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("black plots L%0d", g + 1), n_plots[g] - p0[g], NPix);
      check_eq($sformatf("black bad pixels L%0d", g + 1), n_bad[g] - b0[g], 0);
      check_eq($sformatf("black done count L%0d", g + 1), n_done[g] - d0[g], 1);
      check_eq($sformatf("black px(0,5) L%0d", g + 1), int'(fb[g][800]), BorderExp);
      check_eq($sformatf("black px(159,5) L%0d", g + 1), int'(fb[g][959]), BorderExp);
      check_eq($sformatf("black px(7,0) L%0d", g + 1), int'(fb[g][7]), BorderExp);
      check_eq($sformatf("black px(7,119) L%0d", g + 1), int'(fb[g][19047]), BorderExp);
      check_eq($sformatf("black px(1,1) L%0d", g + 1), int'(fb[g][161]), 0);
    end
    snap();
    step(50);
    for (int g = 0; g < 2; g++)
      check_eq($sformatf("black no resweep L%0d", g + 1), n_plots[g] - p0[g], 0);

    // Re-armed sweep, aborted after address 500
    wren = 1'b0;
    step(1);
    snap();
    wren = 1'b1;
    s = cyc;
    run_until(s + 501);
    wren = 1'b0;
    step(10);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("rearm first latency L%0d", g + 1), first_cyc[g] - s, g + 2);
      check_eq($sformatf("abort plots L%0d", g + 1), n_plots[g] - p0[g], 501);
      check_eq($sformatf("abort bad pixels L%0d", g + 1), n_bad[g] - b0[g], 0);
      check_eq($sformatf("abort no done L%0d", g + 1), n_done[g] - d0[g], 0);
      check_eq($sformatf("abort last x L%0d", g + 1), last_x[g], 20);
      check_eq($sformatf("abort last y L%0d", g + 1), last_y[g], 3);
      check_eq($sformatf("abort last plot cycle L%0d", g + 1), last_cyc[g] - s, 502 + g);
      check_eq($sformatf("abort addr idle L%0d", g + 1), int'(o_addr[g]), 0);
    end

    // Flash mode, partial sweep
    draw_black = 1'b0;
    flash = 1'b1;
    exp_mode = 3;
    step(2);
    snap();
    wren = 1'b1;
    s = cyc;
    run_until(s + 1000);
    wren = 1'b0;
    step(10);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("flash plots L%0d", g + 1), n_plots[g] - p0[g], 1000);
      check_eq($sformatf("flash bad pixels L%0d", g + 1), n_bad[g] - b0[g], 0);
      check_eq($sformatf("flash px0 L%0d", g + 1), int'(fb[g][0]), 4);
      check_eq($sformatf("flash px1 L%0d", g + 1), int'(fb[g][1]), 2);
      check_eq($sformatf("flash px998 L%0d", g + 1), int'(fb[g][998]), 4);
      check_eq($sformatf("flash px999 L%0d", g + 1), int'(fb[g][999]), 2);
    end

    // Title beats black; select change mid-sweep is ignored
    flash = 1'b0;
    show_title = 1'b1;
    draw_black = 1'b1;
    exp_mode = 0;
    step(2);
    snap();
    wren = 1'b1;
    s = cyc;
    run_until(s + 100);
    show_title = 1'b0;
    draw_black = 1'b0;
    show_game_over = 1'b1;
    run_until(s + 2000);
    wren = 1'b0;
    step(10);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("latch plots L%0d", g + 1), n_plots[g] - p0[g], 2000);
      check_eq($sformatf("latch bad pixels L%0d", g + 1), n_bad[g] - b0[g], 0);
      check_eq($sformatf("latch px1500 L%0d", g + 1), int'(fb[g][1500]), 4);
      check_eq($sformatf("latch px1999 L%0d", g + 1), int'(fb[g][1999]), 7);
    end

    // Asynchronous reset mid-sweep
    show_game_over = 1'b0;
    show_title = 1'b1;
    step(2);
    wren = 1'b1;
    step(100);
    for (int g = 0; g < 2; g++)
      check_eq($sformatf("pre-reset plot L%0d", g + 1), int'(o_plot[g]), 1);
    rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("async reset plot L%0d", g + 1), int'(o_plot[g]), 0);
      check_eq($sformatf("async reset addr L%0d", g + 1), int'(o_addr[g]), 0);
      check_eq($sformatf("async reset x L%0d", g + 1), int'(o_x[g]), 0);
    end
    wren = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
